// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, and a one-entry
// valid/ready holding register with single-cycle frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int CNT_W        = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_next;
    logic [7:0]       shreg;
    logic [7:0]       shreg_next;
    logic             rx_meta;
    logic             rx_s;
    logic             byte_done;
    logic             frame_err_set;

    // Synchronizer flops reset to the idle level so reset never fakes a start edge.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The stop sample returns to IDLE at once so a back-to-back start edge is not missed.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt + CNT_W'(1);
        bit_next      = bit_idx;
        shreg_next    = shreg;
        byte_done     = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                bit_next = '0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = '0;
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // A completion while full is only accepted if the consumer drains in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            bit_idx     <= bit_next;
            shreg       <= shreg_next;
            o_frame_err <= frame_err_set;
            o_overrun   <= 1'b0;
            if (byte_done) begin
                if (!o_valid || i_ready) begin
                    o_data  <= shreg;
                    o_valid <= 1'b1;
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

    assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; expected bytes go into a queue and a
// monitor compares them at every consumer handshake.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       line;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int         checks;
    int         failures;
    int         fe_count;
    int         ov_count;
    int         valid_rises;
    logic       prev_valid;
    logic       prev_fe;
    logic       prev_ov;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst_n),
        .i_uart_rx  (line),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after each rising edge; the monitor samples on falling edges.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
        line = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            tick(CPB);
        end
        line = stop_bit;
        tick(CPB);
        line = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        exp_q.push_back(b);
        sendFrame(b, 1'b1);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL handshake_unexpected: got %0h expected none", o_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (o_data !== e) begin
                        failures++;
                        $display("[TB] FAIL handshake_data: got %0h expected %0h", o_data, e);
                    end
                end
            end
            if (o_valid && !prev_valid) valid_rises++;
            if (o_frame_err) begin
                fe_count++;
                checks++;
                if (prev_fe) begin
                    failures++;
                    $display("[TB] FAIL frame_err_width: got %0d expected 1 cycle", 2);
                end
            end
            if (o_overrun) begin
                ov_count++;
                checks++;
                if (prev_ov) begin
                    failures++;
                    $display("[TB] FAIL overrun_width: got %0d expected 1 cycle", 2);
                end
            end
        end
        prev_valid = o_valid;
        prev_fe    = o_frame_err;
        prev_ov    = o_overrun;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vr;
        checks      = 0;
        failures    = 0;
        fe_count    = 0;
        ov_count    = 0;
        valid_rises = 0;
        prev_valid  = 1'b0;
        prev_fe     = 1'b0;
        prev_ov     = 1'b0;
        rst_n       = 1'b0;
        line        = 1'b1;
        i_ready     = 1'b0;
        tick(3);
        checkOutput("reset_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("reset_data", {24'd0, o_data}, 32'd0);
        checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset_frame_err", {31'd0, o_frame_err}, 32'd0);
        checkOutput("reset_overrun", {31'd0, o_overrun}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // Single byte: o_valid rises on the edge right after the stop-bit sample.
        fork
            applyStimulus(8'hA5);
            begin
                tick(154);
                checkOutput("valid_at_stop_sample", {31'd0, o_valid}, 32'd0);
                tick(1);
                checkOutput("valid_after_stop_sample", {31'd0, o_valid}, 32'd1);
            end
        join
        tick(20);
        checkOutput("single_valid_held", {31'd0, o_valid}, 32'd1);
        checkOutput("single_data_held", {24'd0, o_data}, 32'hA5);
        i_ready = 1'b1;
        tick(1);
        i_ready = 1'b0;
        checkOutput("single_valid_cleared", {31'd0, o_valid}, 32'd0);

        // Back-to-back frames with the consumer always ready.
        i_ready = 1'b1;
        applyStimulus(8'h00);
        applyStimulus(8'hFF);
        applyStimulus(8'h3C);
        tick(20);
        checkOutput("b2b_frame_err", fe_count, 32'd0);
        checkOutput("b2b_overrun", ov_count, 32'd0);

        // False start: a 5-cycle low glitch is rejected at the start-bit sample.
        vr   = valid_rises;
        line = 1'b0;
        tick(5);
        checkOutput("false_start_busy", {31'd0, o_busy}, 32'd1);
        line = 1'b1;
        tick(20);
        checkOutput("false_start_idle", {31'd0, o_busy}, 32'd0);
        checkOutput("false_start_no_valid", valid_rises, vr);
        applyStimulus(8'h5A);
        tick(20);

        // Frame error followed by a long break.
        vr = valid_rises;
        sendFrame(8'h81, 1'b0);
        line = 1'b0;
        tick(40 * CPB);
        checkOutput("break_busy", {31'd0, o_busy}, 32'd1);
        checkOutput("break_one_frame_err", fe_count, 32'd1);
        checkOutput("break_no_valid", valid_rises, vr);
        line = 1'b1;
        tick(5);
        checkOutput("break_released", {31'd0, o_busy}, 32'd0);
        applyStimulus(8'h42);
        tick(20);
        checkOutput("break_frame_err_total", fe_count, 32'd1);

        // Overrun, then a drain exactly on the completion cycle of the next byte.
        i_ready = 1'b0;
        applyStimulus(8'h11);
        sendFrame(8'h22, 1'b1);
        tick(5);
        checkOutput("overrun_pulse", ov_count, 32'd1);
        checkOutput("overrun_data_kept", {24'd0, o_data}, 32'h11);
        checkOutput("overrun_valid_kept", {31'd0, o_valid}, 32'd1);
        fork
            applyStimulus(8'h33);
            begin
                tick(154);
                i_ready = 1'b1;
                tick(1);
                i_ready = 1'b0;
            end
        join
        tick(5);
        checkOutput("drain_no_overrun", ov_count, 32'd1);
        checkOutput("drain_valid", {31'd0, o_valid}, 32'd1);
        checkOutput("drain_data", {24'd0, o_data}, 32'h33);

        // Reset during bit 4 of 0xC3, released while the line is high for the rest of the frame.
        vr = valid_rises;
        fork
            sendFrame(8'hC3, 1'b1);
            begin
                tick(4 * CPB + CPB + 8);
                rst_n = 1'b0;
                #1;
                exp_q.delete();
                checkOutput("midreset_valid", {31'd0, o_valid}, 32'd0);
                checkOutput("midreset_data", {24'd0, o_data}, 32'd0);
                checkOutput("midreset_busy", {31'd0, o_busy}, 32'd0);
                tick(30);
                rst_n = 1'b1;
            end
        join
        tick(30);
        checkOutput("midreset_no_valid", valid_rises, vr);
        checkOutput("midreset_valid_low", {31'd0, o_valid}, 32'd0);
        i_ready = 1'b1;
        applyStimulus(8'h99);

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        checkOutput("final_frame_err_total", fe_count, 32'd1);
        checkOutput("final_overrun_total", ov_count, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
